// File: rtl/lte_sym_sched_if.sv
// Bundle of slot configuration, core handshake and per-symbol control signals
// exchanged between the LTE symbol scheduler and its environment.
//   master : slot/config/core_done producer (testbench or slot controller)
//   slave  : the scheduler itself (lte_sym_sched)
// Signals:
//   slot_start, cfg_en, cfg_fft_type, cfg_cp_type, cfg_fft_num[2:0], cfg_fs_ratio[6:0],
//   core_done                                       -> into the scheduler
//   fft_start, fft_type, cp_type, fft_num[2:0], fs_ratio[6:0], fst_cp, sym_idx[2:0],
//   busy, slot_done, sym_late, slot_err            <- out of the scheduler
interface lte_sym_sched_if;
    logic       slot_start;
    logic       cfg_en;
    logic       cfg_fft_type;
    logic       cfg_cp_type;
    logic [2:0] cfg_fft_num;
    logic [6:0] cfg_fs_ratio;
    logic       core_done;

    logic       fft_start;
    logic       fft_type;
    logic       cp_type;
    logic [2:0] fft_num;
    logic [6:0] fs_ratio;
    logic       fst_cp;
    logic [2:0] sym_idx;
    logic       busy;
    logic       slot_done;
    logic       sym_late;
    logic       slot_err;

    modport master (
        output slot_start, cfg_en, cfg_fft_type, cfg_cp_type, cfg_fft_num, cfg_fs_ratio,
        output core_done,
        input  fft_start, fft_type, cp_type, fft_num, fs_ratio, fst_cp, sym_idx,
        input  busy, slot_done, sym_late, slot_err
    );

    modport slave (
        input  slot_start, cfg_en, cfg_fft_type, cfg_cp_type, cfg_fft_num, cfg_fs_ratio,
        input  core_done,
        output fft_start, fft_type, cp_type, fft_num, fs_ratio, fst_cp, sym_idx,
        output busy, slot_done, sym_late, slot_err
    );
endinterface

// File: rtl/lte_sym_sched.sv
// Per-slot OFDM symbol scheduler for the LTE FFT/IFFT chain.
// On slot_start (with cfg_en) it latches and clamps the slot configuration, computes the
// symbol periods (N + CP) * fs_ratio, then issues one fft_start per symbol (7 normal CP,
// 6 extended CP) paced by a down-counting timer and gated by the core's completion.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   bus   - lte_sym_sched_if.slave: slot/config/core_done in, per-symbol controls and
//           status pulses (fft_start, slot_done, sym_late, slot_err) out
module lte_sym_sched #(
    parameter int unsigned TMR_NBIT = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    lte_sym_sched_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StLatch, StRun, StSlotEnd} state_e;

    localparam logic [TMR_NBIT-1:0] TmrOne = TMR_NBIT'(1);

    state_e              state_q;
    logic                fft_type_q;
    logic                cp_type_q;
    logic [2:0]          fft_num_q;
    logic [6:0]          fs_ratio_q;
    logic [TMR_NBIT-1:0] p0_q;
    logic [TMR_NBIT-1:0] p1_q;
    logic [TMR_NBIT-1:0] timer_q;
    logic                done_seen_q;
    logic [2:0]          idx_q;
    logic                fst_q;
    logic                first_q;   // first RUN cycle: symbol 0 start
    logic                late_q;    // sym_late already reported for this symbol

    // Period arithmetic from the latched (clamped) configuration.
    logic [11:0] n_len;
    logic [11:0] cp0_len;
    logic [11:0] cp1_len;
    logic [11:0] sum0;
    logic [11:0] sum1;
    logic [18:0] prod0;
    logic [18:0] prod1;

    assign n_len   = 12'd2048 >> fft_num_q;
    assign cp0_len = cp_type_q ? (12'd512 >> fft_num_q) : (12'd160 >> fft_num_q);
    assign cp1_len = cp_type_q ? (12'd512 >> fft_num_q) : (12'd144 >> fft_num_q);
    assign sum0    = n_len + cp0_len;
    assign sum1    = n_len + cp1_len;
    assign prod0   = 19'(sum0) * 19'(fs_ratio_q);
    assign prod1   = 19'(sum1) * 19'(fs_ratio_q);

    logic [2:0] last_idx;
    logic       expired;
    logic       done_any;
    logic       adv;
    logic       fin;
    logic       late_now;

    assign last_idx = cp_type_q ? 3'd5 : 3'd6;
    // The start cycle itself never counts as expiry; core_done there is ignored.
    assign expired  = (state_q == StRun) && !first_q && (timer_q == '0);
    assign done_any = done_seen_q || bus.core_done;
    assign adv      = expired && done_any && (idx_q != last_idx);
    assign fin      = expired && done_any && (idx_q == last_idx);
    assign late_now = expired && !done_any && !late_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fft_type_q  <= 1'b0;
            cp_type_q   <= 1'b0;
            fft_num_q   <= 3'd0;
            fs_ratio_q  <= 7'd0;
            p0_q        <= '0;
            p1_q        <= '0;
            timer_q     <= '0;
            done_seen_q <= 1'b0;
            idx_q       <= 3'd0;
            fst_q       <= 1'b0;
            first_q     <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.slot_start && bus.cfg_en) begin
                        fft_type_q <= bus.cfg_fft_type;
                        cp_type_q  <= bus.cfg_cp_type;
                        fft_num_q  <= (bus.cfg_fft_num > 3'd4) ? 3'd4 : bus.cfg_fft_num;
                        fs_ratio_q <= (bus.cfg_fs_ratio == 7'd0) ? 7'd1 : bus.cfg_fs_ratio;
                        idx_q      <= 3'd0;
                        fst_q      <= 1'b0;
                        state_q    <= StLatch;
                    end
                end
                StLatch: begin
                    p0_q    <= TMR_NBIT'(prod0);
                    p1_q    <= TMR_NBIT'(prod1);
                    first_q <= 1'b1;
                    fst_q   <= 1'b1;
                    idx_q   <= 3'd0;
                    state_q <= StRun;
                end
                StRun: begin
                    // Timer loads P-1 in each start cycle so it hits 0 exactly P cycles
                    // after the start, which is when the next start may be issued.
                    if (first_q) begin
                        first_q     <= 1'b0;
                        timer_q     <= p0_q - TmrOne;
                        done_seen_q <= 1'b0;
                        late_q      <= 1'b0;
                    end else if (adv) begin
                        idx_q       <= idx_q + 3'd1;
                        fst_q       <= 1'b0;
                        timer_q     <= p1_q - TmrOne;
                        done_seen_q <= 1'b0;
                        late_q      <= 1'b0;
                    end else if (fin) begin
                        done_seen_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= StSlotEnd;
                    end else begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - TmrOne;
                        end
                        if (bus.core_done) begin
                            done_seen_q <= 1'b1;
                        end
                        if (late_now) begin
                            late_q <= 1'b1;
                        end
                    end
                end
                StSlotEnd: begin
                    idx_q   <= 3'd0;
                    fst_q   <= 1'b0;
                    late_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Starts after symbol 0 fire in the very cycle the period/core_done condition is met,
    // so fft_start, sym_idx and fst_cp look ahead to the symbol being started.
    assign bus.fft_start = first_q || adv;
    assign bus.sym_idx   = adv ? (idx_q + 3'd1) : idx_q;
    assign bus.fst_cp    = fst_q && !adv;
    assign bus.fft_type  = fft_type_q;
    assign bus.cp_type   = cp_type_q;
    assign bus.fft_num   = fft_num_q;
    assign bus.fs_ratio  = fs_ratio_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.slot_done = (state_q == StSlotEnd);
    assign bus.sym_late  = late_now;
    assign bus.slot_err  = (state_q != StIdle) && bus.slot_start;

endmodule

// File: tb/tb_lte_sym_sched.sv
// Scoreboard bench for lte_sym_sched: directed slots push expected start/late/done/err
// events into queues; a monitor pops and compares whenever the DUT raises an event.
module tb_lte_sym_sched;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lte_sym_sched_if bus ();

    lte_sym_sched #(.TMR_NBIT(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int idx;
        int fst;
        int num;
        int ratio;
        int cp;
        int typ;
    } start_t;

    start_t q_start[$];
    int     q_late[$];
    int     q_done[$];
    int     q_err[$];
    int     dly[7];
    int     done_due;
    int     total;
    int     bad;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s @cyc %0d: got event expected none", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        start_t e;
        int     c;
        forever begin
            @(negedge clk);
            if (bus.fft_start) begin
                if (q_start.size() == 0) unexpected("unexpected_start");
                else begin
                    e = q_start.pop_front();
                    check("start_cyc", cyc, e.cyc);
                    check("start_idx", int'(bus.sym_idx), e.idx);
                    check("start_fst", int'(bus.fst_cp), e.fst);
                    check("start_num", int'(bus.fft_num), e.num);
                    check("start_ratio", int'(bus.fs_ratio), e.ratio);
                    check("start_cp", int'(bus.cp_type), e.cp);
                    check("start_type", int'(bus.fft_type), e.typ);
                    done_due = cyc + dly[e.idx];
                end
            end
            if (bus.sym_late) begin
                if (q_late.size() == 0) unexpected("unexpected_late");
                else begin
                    c = q_late.pop_front();
                    check("late_cyc", cyc, c);
                end
            end
            if (bus.slot_done) begin
                if (q_done.size() == 0) unexpected("unexpected_slot_done");
                else begin
                    c = q_done.pop_front();
                    check("slot_done_cyc", cyc, c);
                end
            end
            if (bus.slot_err) begin
                if (q_err.size() == 0) unexpected("unexpected_slot_err");
                else begin
                    c = q_err.pop_front();
                    check("slot_err_cyc", cyc, c);
                end
            end
        end
    endtask

    // Core model: one core_done pulse dly[idx] cycles after each start.
    task automatic responder();
        forever begin
            @(posedge clk);
            #1;
            bus.core_done = (cyc == done_due);
        end
    endtask

    task automatic issue_slot(input int en, input int typ, input int cp, input int num,
                              input int ratio, output int t);
        bus.cfg_en       = en[0];
        bus.cfg_fft_type = typ[0];
        bus.cfg_cp_type  = cp[0];
        bus.cfg_fft_num  = num[2:0];
        bus.cfg_fs_ratio = ratio[6:0];
        bus.slot_start   = 1'b1;
        t = cyc;
        tick();
        bus.slot_start = 1'b0;
    endtask

    // Expected schedule from hand-computed periods p0/p1 and the core delays in dly[].
    task automatic expect_slot(input int t, input int last, input int p0, input int p1,
                               input int num, input int ratio, input int cp, input int typ);
        start_t e;
        int     s;
        int     p;
        int     nxt;
        s = t + 2;
        for (int k = 0; k <= last; k++) begin
            e.cyc = s; e.idx = k; e.fst = (k == 0) ? 1 : 0;
            e.num = num; e.ratio = ratio; e.cp = cp; e.typ = typ;
            q_start.push_back(e);
            p = (k == 0) ? p0 : p1;
            if (dly[k] > p) q_late.push_back(s + p);
            nxt = s + ((dly[k] > p) ? dly[k] : p);
            if (k == last) q_done.push_back(nxt + 1);
            s = nxt;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_start.size() != 0 || q_late.size() != 0 || q_done.size() != 0 ||
                q_err.size() != 0 || bus.busy) && n < 6000) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n >= 6000) ? 1 : 0, 0);
        q_start.delete(); q_late.delete(); q_done.delete(); q_err.delete();
        repeat (3) tick();
    endtask

    task automatic check_zero(input string name);
        check({name, "_fft_start"}, int'(bus.fft_start), 0);
        check({name, "_fft_type"}, int'(bus.fft_type), 0);
        check({name, "_cp_type"}, int'(bus.cp_type), 0);
        check({name, "_fft_num"}, int'(bus.fft_num), 0);
        check({name, "_fs_ratio"}, int'(bus.fs_ratio), 0);
        check({name, "_fst_cp"}, int'(bus.fst_cp), 0);
        check({name, "_sym_idx"}, int'(bus.sym_idx), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_slot_done"}, int'(bus.slot_done), 0);
        check({name, "_sym_late"}, int'(bus.sym_late), 0);
        check({name, "_slot_err"}, int'(bus.slot_err), 0);
    endtask

    initial begin
        int t;
        total = 0;
        bad = 0;
        done_due = -1;
        for (int i = 0; i < 7; i++) dly[i] = 20;
        reset = 1'b1;
        bus.slot_start = 1'b0;
        bus.cfg_en = 1'b0;
        bus.cfg_fft_type = 1'b0;
        bus.cfg_cp_type = 1'b0;
        bus.cfg_fft_num = 3'd0;
        bus.cfg_fs_ratio = 7'd0;
        bus.core_done = 1'b0;
        fork
            monitor();
            responder();
            begin
                #1000000;
                $display("FAIL watchdog @cyc %0d: got no finish expected finish", cyc);
                $fatal(1, "watchdog expired");
            end
        join_none

        tick(); tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Normal CP, N=128, ratio 1: P0 = 138, P1 = 137.
        issue_slot(1, 0, 0, 4, 1, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 0);
        drain("normal");

        // Extended CP, N=256, ratio 2: (256+64)*2 = 640.
        issue_slot(1, 1, 1, 3, 2, t);
        expect_slot(t, 5, 640, 640, 3, 2, 1, 1);
        drain("extended");

        // Core late on symbol 2: done 50 cycles after expiry (137+50).
        dly[2] = 187;
        issue_slot(1, 0, 0, 4, 1, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 0);
        drain("late");
        dly[2] = 20;

        // slot_start while busy (mid-slot and in the SLOT_END cycle) -> slot_err only.
        issue_slot(1, 1, 0, 4, 1, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 1);
        while (cyc < t + 300) tick();
        bus.cfg_en = 1'b1; bus.cfg_fft_num = 3'd0; bus.cfg_cp_type = 1'b1;
        bus.slot_start = 1'b1;
        q_err.push_back(cyc);
        tick();
        bus.slot_start = 1'b0;
        while (cyc < t + 963) tick();
        bus.slot_start = 1'b1;
        q_err.push_back(cyc);
        tick();
        bus.slot_start = 1'b0;
        drain("busy");

        // Disabled slot_start in IDLE: nothing happens, config holds.
        issue_slot(0, 0, 1, 0, 9, t);
        repeat (10) tick();
        check("disabled_busy", int'(bus.busy), 0);
        check("disabled_fft_num", int'(bus.fft_num), 4);
        check("disabled_fft_type", int'(bus.fft_type), 1);
        check("disabled_cp_type", int'(bus.cp_type), 0);

        // Clamp: code 7 -> 4, ratio 0 -> 1.
        issue_slot(1, 0, 0, 7, 0, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 0);
        drain("clamp");

        // Reset during symbol 3 (starts at t+414, next due t+551).
        issue_slot(1, 1, 0, 4, 1, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 1);
        while (cyc < t + 450) tick();
        #3;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        q_start.delete(); q_late.delete(); q_done.delete(); q_err.delete();
        tick(); tick();
        reset = 1'b0;
        tick();
        issue_slot(1, 0, 0, 4, 1, t);
        expect_slot(t, 6, 138, 137, 4, 1, 0, 0);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lte_sym_sched.md
Name: lte_sym_sched

Overview:
- Per-slot symbol scheduler for the LTE FFT/IFFT chain.
- On each slot_start it latches the slot configuration and issues one fft_start per OFDM symbol to the FFT core: 7 symbols for normal CP, 6 for extended CP.
- Starts are paced at the symbol period (FFT length + CP length) × fs_ratio clocks.
- It drives the per-symbol controls (fft_type, cp_type, fft_num, fs_ratio, fst_cp) consumed by the FFT core and the CP post-processor, and flags late core completions.

Parameters:
- TMR_NBIT, 20, symbol-period timer width; must hold (2048+512)×127.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- slot_start  in  1  one-cycle pulse, start of slot
- cfg_en  in  1  scheduler enable, sampled only with slot_start
- cfg_fft_type  in  1  0 FFT, 1 IFFT
- cfg_cp_type  in  1  0 normal, 1 extended
- cfg_fft_num  in  3  FFT size code: N = 2048>>code
- cfg_fs_ratio  in  7  clock/sample ratio
- core_done  in  1  pulse, FFT core finished current symbol
- fft_start  out  1  one-cycle pulse, start symbol
- fft_type  out  1  latched type
- cp_type  out  1  latched CP type
- fft_num  out  3  latched, clamped size code
- fs_ratio  out  7  latched, clamped ratio
- fst_cp  out  1  high while symbol 0 is active
- sym_idx  out  3  current symbol index, 0..6
- busy  out  1  state != IDLE
- slot_done  out  1  one-cycle pulse after last symbol
- sym_late  out  1  one-cycle pulse, period expired without core_done
- slot_err  out  1  one-cycle pulse, slot_start ignored while busy

Behaviour:
- Configuration, exactly as decided: one clock, `clk`; `reset` is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; timer 0; done_seen 0.
- Config clamping: cfg_fft_num codes 5..7 clamp to 4 (N=128). cfg_fs_ratio=0 is treated as 1.
- Derived quantities:
  - N = 2048>>num.
  - CP lengths: first normal symbol = 160>>num; other normal symbols = 144>>num; extended = 512>>num.
  - Symbol period: P0 = (N + CP of symbol 0) × ratio; P1 = (N + CP of symbols 1..last) × ratio.
  - Registered products computed in LATCH; no combinational multiplier feeds the timer directly.
- Symbol count: last = 6 for normal CP, 5 for extended.
- IDLE:
  - On slot_start & cfg_en: latch all cfg_* into the outputs, go to LATCH.
  - On slot_start & ~cfg_en: stay in IDLE.
  - core_done is ignored in IDLE.
- LATCH (1 cycle):
  - Compute P0/P1; go to RUN.
  - Assert fft_start in the first RUN cycle with sym_idx=0 and fst_cp=1.
  - Latency: slot_start at cycle t gives fft_start at t+2.
- RUN:
  - At each fft_start: timer <= Pk-1 (P0 for symbol 0, else P1); clear done_seen.
  - Each later cycle, the timer decrements while >0.
  - core_done sets done_seen. core_done in the same cycle as fft_start is ignored.
  - When timer==0 and (done_seen | core_done):
    - If sym_idx==last, go to SLOT_END.
    - Otherwise: sym_idx+1, fst_cp=0, fft_start, reload the timer.
    - With a timely core_done, consecutive starts are spaced exactly P0 (after symbol 0) or P1 clocks.
  - When timer reaches 0 without done: pulse sym_late once, then wait indefinitely for core_done and issue the next start in the cycle core_done arrives.
- SLOT_END (1 cycle): pulse slot_done; clear sym_idx and fst_cp; go to IDLE. A slot_start in this cycle is treated as while-busy.
- While busy:
  - slot_start pulses slot_err and is otherwise ignored.
  - Output configuration stays stable for the whole slot.
- Reset mid-slot: abort immediately to the reset values; no slot_done is issued.

Test Plan:
- Normal CP, code 4, ratio 1, core_done 20 cycles after each start → slot_start at t gives fft_start at t+2, then t+140 (P0=138), then +137 each time (P1=137). Exactly 7 starts, sym_idx 0..6, fst_cp high only for the first. slot_done 1 cycle after the last timer expiry.
- Extended CP, code 3, ratio 2 → 6 starts spaced (256+64)×2=640; fst_cp high only on symbol 0; slot_done once.
- Code 4, ratio 1, core_done withheld on symbol 2 until 50 cycles after its timer expiry → one sym_late pulse at expiry; next fft_start in the same cycle as core_done; no duplicate start.
- slot_start while busy, plus slot_start with cfg_en=0 in IDLE → slot_err pulses only in the busy case; no fft_start in the disabled case; outputs unchanged.
- Clamp check: cfg_fft_num=7, cfg_fs_ratio=0 → fft_num=4, fs_ratio=1, normal-CP spacing 138/137.
- Assert reset during symbol 3 → all outputs 0 asynchronously; after release, a new slot_start restarts at sym_idx 0 with t+2 latency.
